banner_display_ctrl: RTL and testbench

//  Sequences the 28x8 text-banner ROMs (START / WIN / LOSE glyph ROMs) onto the VGA raster.

---
 rtl/banner_display_ctrl.sv | 175 +++++++++++++++++
 tb/tb_banner_display_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/banner_display_ctrl.sv
// Banner sequencer: selects START/WIN/LOSE glyph ROM, maps scan position to ROM
// addresses, blinks and times out the banner. Pixel path latency is 3 clocks.
module banner_display_ctrl #(
  parameter int          ORIGIN_X     = 256,
  parameter int          ORIGIN_Y     = 224,
  parameter int          SHIFT        = 2,
  parameter int          BLINK_FRAMES = 30,
  parameter int          HOLD_FRAMES  = 180,
  parameter logic [11:0] NULL_COLOR   = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [9:0]  pix_x,
  input  logic [8:0]  pix_y,
  input  logic        req_start,
  input  logic        req_win,
  input  logic        req_lose,
  input  logic        clear,
  input  logic [11:0] start_color,
  input  logic [11:0] win_color,
  input  logic [11:0] lose_color,
  output logic [5:0]  rom_x,
  output logic [2:0]  rom_y,
  output logic [11:0] pix_color,
  output logic        banner_on,
  output logic        banner_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_HIDE = 2'd2;

  localparam logic [1:0] SEL_NONE  = 2'd0;
  localparam logic [1:0] SEL_START = 2'd1;
  localparam logic [1:0] SEL_WIN   = 2'd2;
  localparam logic [1:0] SEL_LOSE  = 2'd3;

  localparam logic [9:0] ORG_X      = 10'(ORIGIN_X);
  localparam logic [8:0] ORG_Y      = 9'(ORIGIN_Y);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
  localparam logic       HOLD_EN    = (HOLD_FRAMES != 0);

  logic [1:0]  state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  blink_q, blink_d;
  logic [7:0]  hold_q, hold_d;
  logic        banner_on_q, banner_on_d;
  logic        banner_done_q, banner_done_d;
  logic [5:0]  rom_x_q, rom_x_d;
  logic [2:0]  rom_y_q, rom_y_d;
  logic        in_win_d1_q, in_win_d2_q;
  logic        vis_d1_q, vis_d2_q;
  logic [1:0]  sel_d1_q, sel_d2_q;
  logic [11:0] pix_color_q, pix_color_d;
  logic        any_req_s, in_win_s;
  logic [9:0]  dx_s, cx_s;
  logic [8:0]  dy_s, cy_s;
  logic [11:0] rom_color_s;

  // Control FSM: clear beats requests, requests beat frame-tick counting.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    blink_d       = blink_q;
    hold_d        = hold_q;
    banner_done_d = 1'b0;
    any_req_s     = req_start | req_win | req_lose;
    if (clear) begin
      state_d = ST_IDLE;
      sel_d   = SEL_NONE;
      blink_d = 8'd0;
      hold_d  = 8'd0;
    end else if (any_req_s) begin
      state_d = ST_SHOW;
      sel_d   = req_lose ? SEL_LOSE : (req_win ? SEL_WIN : SEL_START);
      blink_d = 8'd0;
      hold_d  = 8'd0;
    end else if (frame_tick && (state_q != ST_IDLE)) begin
      if (HOLD_EN && (hold_q == HOLD_LAST)) begin
        state_d       = ST_IDLE;
        sel_d         = SEL_NONE;
        blink_d       = 8'd0;
        hold_d        = 8'd0;
        banner_done_d = 1'b1;
      end else begin
        hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
        if (blink_q == BLINK_LAST) begin
          blink_d = 8'd0;
          state_d = (state_q == ST_SHOW) ? ST_HIDE : ST_SHOW;
        end else begin
          blink_d = (blink_q == 8'hFF) ? blink_q : blink_q + 8'd1;
        end
      end
    end else begin
      state_d = state_q;
    end
    banner_on_d = (state_d != ST_IDLE);
  end

  // Address stage: out-of-window positions park the ROM at (0,0).
  always_comb begin
    dx_s     = pix_x - ORG_X;
    dy_s     = pix_y - ORG_Y;
    cx_s     = dx_s >> SHIFT;
    cy_s     = dy_s >> SHIFT;
    in_win_s = (pix_x >= ORG_X) && (cx_s < 10'd28) && (pix_y >= ORG_Y) && (cy_s < 9'd8);
    if (in_win_s) begin
      rom_x_d = cx_s[5:0];
      rom_y_d = cy_s[2:0];
    end else begin
      rom_x_d = 6'd0;
      rom_y_d = 3'd0;
    end
  end

  // Output stage: choose the ROM matching the selection captured at pipe entry.
  always_comb begin
    case (sel_d2_q)
      SEL_START: rom_color_s = start_color;
      SEL_WIN:   rom_color_s = win_color;
      SEL_LOSE:  rom_color_s = lose_color;
      default:   rom_color_s = NULL_COLOR;
    endcase
    if (in_win_d2_q && vis_d2_q) begin
      pix_color_d = rom_color_s;
    end else begin
      pix_color_d = NULL_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sel_q         <= SEL_NONE;
      blink_q       <= 8'd0;
      hold_q        <= 8'd0;
      banner_on_q   <= 1'b0;
      banner_done_q <= 1'b0;
      rom_x_q       <= 6'd0;
      rom_y_q       <= 3'd0;
      in_win_d1_q   <= 1'b0;
      in_win_d2_q   <= 1'b0;
      vis_d1_q      <= 1'b0;
      vis_d2_q      <= 1'b0;
      sel_d1_q      <= SEL_NONE;
      sel_d2_q      <= SEL_NONE;
      pix_color_q   <= NULL_COLOR;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      blink_q       <= blink_d;
      hold_q        <= hold_d;
      banner_on_q   <= banner_on_d;
      banner_done_q <= banner_done_d;
      rom_x_q       <= rom_x_d;
      rom_y_q       <= rom_y_d;
      in_win_d1_q   <= in_win_s;
      in_win_d2_q   <= in_win_d1_q;
      vis_d1_q      <= (state_q == ST_SHOW);
      vis_d2_q      <= vis_d1_q;
      sel_d1_q      <= sel_q;
      sel_d2_q      <= sel_d1_q;
      pix_color_q   <= pix_color_d;
    end
  end

  assign rom_x       = rom_x_q;
  assign rom_y       = rom_y_q;
  assign pix_color   = pix_color_q;
  assign banner_on   = banner_on_q;
  assign banner_done = banner_done_q;

endmodule

// File: tb/tb_banner_display_ctrl.sv
// Scoreboard bench for banner_display_ctrl: ROM models echo (tag,row,col) so the
// colour check also proves the address mapping and ROM selection.
module tb_banner_display_ctrl;

  logic        clk = 1'b0;
  logic        rst, frame_tick, req_start, req_win, req_lose, clear;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [11:0] start_color, win_color, lose_color;
  logic [5:0]  rom_x, rom_x2;
  logic [2:0]  rom_y, rom_y2;
  logic [11:0] pix_color, pix_color2;
  logic        banner_on, banner_on2, banner_done, banner_done2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int d1_hits, d2_hits;
  logic [3:0] m_tag;
  logic       m_vis;

  typedef struct { int due; logic [5:0] rx; logic [2:0] ry; } rom_exp_t;
  typedef struct { int due; logic [11:0] col; } col_exp_t;
  rom_exp_t rom_q[$];
  col_exp_t col_q[$];

  localparam logic [3:0] TAG_START = 4'h5;
  localparam logic [3:0] TAG_WIN   = 4'h2;
  localparam logic [3:0] TAG_LOSE  = 4'h3;

  banner_display_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .pix_x(pix_x), .pix_y(pix_y),
    .req_start(req_start), .req_win(req_win), .req_lose(req_lose), .clear(clear),
    .start_color(start_color), .win_color(win_color), .lose_color(lose_color),
    .rom_x(rom_x), .rom_y(rom_y), .pix_color(pix_color),
    .banner_on(banner_on), .banner_done(banner_done)
  );

  banner_display_ctrl #(.HOLD_FRAMES(0)) dut_nohold (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .pix_x(pix_x), .pix_y(pix_y),
    .req_start(req_start), .req_win(req_win), .req_lose(req_lose), .clear(clear),
    .start_color(start_color), .win_color(win_color), .lose_color(lose_color),
    .rom_x(rom_x2), .rom_y(rom_y2), .pix_color(pix_color2),
    .banner_on(banner_on2), .banner_done(banner_done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read ROM models: one clock from address to colour.
  always @(posedge clk) begin
    start_color <= {TAG_START, rom_y, rom_x[4:0]};
    win_color   <= {TAG_WIN,   rom_y, rom_x[4:0]};
    lose_color  <= {TAG_LOSE,  rom_y, rom_x[4:0]};
  end

  function automatic void model_pix(input int x, input int y, output logic [5:0] rx,
                                    output logic [2:0] ry, output logic [11:0] col);
    logic inw;
    inw = (x >= 256) && ((x - 256) / 4 < 28) && (y >= 224) && ((y - 224) / 4 < 8);
    rx  = inw ? 6'((x - 256) / 4) : 6'd0;
    ry  = inw ? 3'((y - 224) / 4) : 3'd0;
    col = (inw && m_vis && (m_tag != 4'h0)) ? {m_tag, ry, rx[4:0]} : 12'h000;
  endfunction

  task automatic clk_step();
    rom_exp_t re;
    col_exp_t ce;
    @(negedge clk);
    if (rom_q.size() > 0 && rom_q[0].due == cyc) begin
      re = rom_q.pop_front();
      checks++;
      if ({rom_x, rom_y} !== {re.rx, re.ry}) begin
        errors++;
        $display("FAIL rom_addr got x=%0d y=%0d want x=%0d y=%0d", rom_x, rom_y, re.rx, re.ry);
      end
    end
    if (col_q.size() > 0 && col_q[0].due == cyc) begin
      ce = col_q.pop_front();
      checks++;
      if (pix_color !== ce.col) begin
        errors++;
        $display("FAIL pix_color got %h want %h", pix_color, ce.col);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_pix(input int x, input int y);
    rom_exp_t re;
    col_exp_t ce;
    pix_x = 10'(x);
    pix_y = 9'(y);
    model_pix(x, y, re.rx, re.ry, ce.col);
    re.due = cyc + 1;
    ce.due = cyc + 3;
    rom_q.push_back(re);
    col_q.push_back(ce);
    clk_step();
  endtask

  task automatic drain();
    pix_x = 10'd0;
    pix_y = 9'd0;
    for (int i = 0; i < 8 && (rom_q.size() + col_q.size()) > 0; i++) clk_step();
    if ((rom_q.size() + col_q.size()) > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d want 0", rom_q.size() + col_q.size());
      rom_q.delete();
      col_q.delete();
    end
  endtask

  task automatic pulse(input logic s, input logic w, input logic l, input logic c);
    req_start = s; req_win = w; req_lose = l; clear = c;
    @(posedge clk); #1;
    req_start = 1'b0; req_win = 1'b0; req_lose = 1'b0; clear = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
      d1_hits += int'(banner_done);
      d2_hits += int'(banner_done2);
      @(posedge clk); #1;
      d1_hits += int'(banner_done);
      d2_hits += int'(banner_done2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_lose = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rom_x !== 6'd0) begin errors++; $display("FAIL rst_rom_x got %0d want 0", rom_x); end
    checks++; if (rom_y !== 3'd0) begin errors++; $display("FAIL rst_rom_y got %0d want 0", rom_y); end
    checks++; if (pix_color !== 12'h000) begin errors++; $display("FAIL rst_pix_color got %h want 000", pix_color); end
    checks++; if (banner_on !== 1'b0) begin errors++; $display("FAIL rst_banner_on got %b want 0", banner_on); end
    checks++; if (banner_done !== 1'b0) begin errors++; $display("FAIL rst_banner_done got %b want 0", banner_done); end
    req_lose = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (banner_on !== 1'b0) begin errors++; $display("FAIL rst_req_ignored banner_on got %b want 0", banner_on); end
  endtask

  task automatic test_window();
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    m_tag = TAG_LOSE; m_vis = 1'b1;
    checks++; if (banner_on !== 1'b1) begin errors++; $display("FAIL lose_banner_on got %b want 1", banner_on); end
    send_pix(256, 224); send_pix(367, 255); send_pix(368, 255); send_pix(300, 230);
    send_pix(255, 224); send_pix(256, 223); send_pix(256, 256); send_pix(639, 479);
    send_pix(363, 252);
    drain();
  endtask

  task automatic test_priority();
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    m_tag = TAG_LOSE;
    send_pix(280, 240); drain();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    m_tag = TAG_START;
    send_pix(280, 240); send_pix(259, 227); drain();
    pulse(1'b0, 1'b1, 1'b0, 1'b1);
    m_tag = 4'h0; m_vis = 1'b0;
    checks++; if (banner_on !== 1'b0) begin errors++; $display("FAIL clear_prio banner_on got %b want 0", banner_on); end
    send_pix(280, 240); drain();
  endtask

  task automatic test_blink();
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    m_tag = TAG_WIN; m_vis = 1'b1;
    ticks(29);
    send_pix(300, 250); drain();
    ticks(1);
    m_vis = 1'b0;
    checks++; if (banner_on !== 1'b1) begin errors++; $display("FAIL hide_banner_on got %b want 1", banner_on); end
    send_pix(300, 250); drain();
    ticks(30);
    m_vis = 1'b1;
    send_pix(300, 250); drain();
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    m_tag = 4'h0; m_vis = 1'b0;
  endtask

  task automatic test_hold();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    m_tag = TAG_START; m_vis = 1'b1;
    d1_hits = 0; d2_hits = 0;
    ticks(179);
    checks++; if (d1_hits != 0) begin errors++; $display("FAIL early_done got %0d pulses want 0", d1_hits); end
    checks++; if (banner_on !== 1'b1) begin errors++; $display("FAIL pre_timeout banner_on got %b want 1", banner_on); end
    ticks(1);
    checks++; if (d1_hits != 1) begin errors++; $display("FAIL done_pulse got %0d cycles want 1", d1_hits); end
    checks++; if (banner_on !== 1'b0) begin errors++; $display("FAIL timeout banner_on got %b want 0", banner_on); end
    m_tag = 4'h0; m_vis = 1'b0;
    send_pix(300, 250); drain();
    ticks(320);
    checks++; if (d2_hits != 0) begin errors++; $display("FAIL nohold_done got %0d pulses want 0", d2_hits); end
    checks++; if (banner_on2 !== 1'b1) begin errors++; $display("FAIL nohold_banner_on got %b want 1", banner_on2); end
    checks++; if (d1_hits != 1) begin errors++; $display("FAIL idle_done got %0d pulses want 1", d1_hits); end
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; req_start = 1'b0; req_win = 1'b0; req_lose = 1'b0;
    clear = 1'b0; pix_x = 10'd0; pix_y = 9'd0; m_tag = 4'h0; m_vis = 1'b0;
    d1_hits = 0; d2_hits = 0;
    @(posedge clk); #1;
    test_reset();
    test_window();
    test_priority();
    test_blink();
    test_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
